// File: rtl/risc32_cp0_reg.sv
// RISC32 coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Commits the MEM/WB CP0 write channel and MEM-stage exception state on the same edge.
module risc32_cp0_reg #(
  parameter logic [31:0] PRID   = 32'h004C0102,
  parameter logic [31:0] CONFIG = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] AddrCount   = 5'd9;
  localparam logic [4:0] AddrCompare = 5'd11;
  localparam logic [4:0] AddrStatus  = 5'd12;
  localparam logic [4:0] AddrCause   = 5'd13;
  localparam logic [4:0] AddrEpc     = 5'd14;
  localparam logic [4:0] AddrPrid    = 5'd15;
  localparam logic [4:0] AddrConfig  = 5'd16;

  localparam logic [31:0] StatusReset = 32'h10000000;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;

  logic        exc_valid;
  logic        exc_eret;
  logic [4:0]  exc_code;

  always_comb begin
    exc_valid = 1'b0;
    exc_eret  = 1'b0;
    exc_code  = 5'd0;
    case (excepttype_i)
      32'h0000_0001: begin exc_valid = 1'b1; exc_code = 5'd0;  end
      32'h0000_0008: begin exc_valid = 1'b1; exc_code = 5'd8;  end
      32'h0000_000a: begin exc_valid = 1'b1; exc_code = 5'd10; end
      32'h0000_000c: begin exc_valid = 1'b1; exc_code = 5'd12; end
      32'h0000_000d: begin exc_valid = 1'b1; exc_code = 5'd13; end
      32'h0000_000e: exc_eret = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    timer_d   = timer_q;

    if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_d = 1'b1;
    end

    // Software write first; the exception update below overrides only the bits it owns.
    if (we_i) begin
      case (waddr_i)
        AddrCount:   count_d = data_i;
        AddrCompare: begin
          compare_d = data_i;
          timer_d   = 1'b0;
        end
        AddrStatus:  status_d = data_i;
        AddrCause:   begin
          cause_d[9:8]   = data_i[9:8];
          cause_d[23:22] = data_i[23:22];
        end
        AddrEpc:     epc_d = data_i;
        default: ;
      endcase
    end

    cause_d[15:10] = int_i;

    if (exc_valid) begin
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
    end else if (exc_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= StatusReset;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      AddrCount:   data_o = count_q;
      AddrCompare: data_o = compare_q;
      AddrStatus:  data_o = status_q;
      AddrCause:   data_o = cause_q;
      AddrEpc:     data_o = epc_q;
      AddrPrid:    data_o = PRID;
      AddrConfig:  data_o = CONFIG;
      default:     data_o = 32'd0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG;
  assign prid_o      = PRID;
  assign timer_int_o = timer_q;

endmodule

// File: doc/risc32_cp0_reg.md
Name: risc32_cp0_reg

Overview:
- Coprocessor-0 register file for the RISC32 pipeline.
- It is the consumer and write end of the CP0 write channel that leaves the MEM/WB pipeline register. It commits cp0_reg_we/addr/data in the WB stage.
- It also holds Count/Compare (with timer interrupt), Status, Cause, EPC, PRId and Config. It records exception state signalled from the MEM stage.
- It sits beside the GPR file. Reads are combinational for the EX stage (mfc0).

Parameters:
- PRID, 32'h004C0102, read-only processor ID value.
- CONFIG, 32'h00008000, read-only Config value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- we_i  in  1  CP0 write enable (from MEM/WB cp0_reg_we_o)
- waddr_i  in  5  CP0 write address (from MEM/WB)
- data_i  in  32  CP0 write data (from MEM/WB)
- raddr_i  in  5  CP0 read address (from EX)
- int_i  in  6  external hardware interrupt lines
- excepttype_i  in  32  exception type from MEM stage
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot
- data_o  out  32  read data (combinational)
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  live register values
- timer_int_o  out  1  timer interrupt request

Behaviour:
- Clock and reset: one clock domain. All state updates on posedge clk. rst=1 at a clock edge, including mid-operation, overrides everything else.
- Register map (waddr/raddr): 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
- Reset values:
  - count 0, compare 0, epc 0, cause 0, timer_int_o 0.
  - status 32'h10000000 (CU0=1).
  - config = CONFIG, prid = PRID (both constant).
- Count:
  - Increments by 1 every non-reset cycle; wraps 32'hFFFFFFFF -> 0.
  - A write to Count loads data_i that cycle; no increment that cycle.
- Timer:
  - When compare != 0 and count == compare (pre-increment value), timer_int_o <= 1 on the next edge.
  - timer_int_o stays sticky until any write to Compare. That write loads Compare and clears timer_int_o in the same edge.
  - compare == 0 never raises the interrupt.
- Status: fully writable.
- Cause:
  - Cause[15:10] <= int_i every cycle; these bits are not software-writable.
  - Software writes affect only IP[9:8], WP[22] and IV[23]. All other bits are owned by hardware.
- EPC: fully writable.
- PRId and Config are read-only. Writes to them, and writes to unmapped addresses, are ignored.
- Exception update (same edge as the WB write):

  | excepttype_i | ExcCode |
  |---|---|
  | 32'h1 (interrupt) | 0 |
  | 32'h8 (syscall) | 8 |
  | 32'ha (reserved instruction) | 10 |
  | 32'hc (overflow) | 12 |
  | 32'hd (trap) | 13 |

  - If Status.EXL (bit1) == 0: EPC <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i; Cause.BD (bit31) <= is_in_delayslot_i.
  - If Status.EXL == 1: EPC and BD are unchanged.
  - In all of the above cases: Status.EXL <= 1 and Cause[6:2] <= ExcCode.
  - 32'he (eret): Status.EXL <= 0 only.
  - Any other value: no exception action.
- Simultaneous software write and exception: the exception wins on the bits it touches (EPC, BD, EXL, ExcCode). The software write still takes effect on all other bits of the addressed register.
- Read path:
  - data_o is a pure combinational function of raddr_i and the current registers. There is no write-to-read bypass; the pipeline forwarding logic handles that.
  - Unmapped addresses read 0. Cause reads return the registered value, including the sampled IP bits.

Test Plan:
- Reset, then idle 5 cycles -> count_o=5, status_o=32'h10000000, cause_o=0, timer_int_o=0; raddr_i=15 gives data_o=32'h004C0102.
- Write Compare=20, let Count run -> timer_int_o rises on the edge after count==20 and stays high; a Compare write of 100 clears it that edge. Separately, Compare=0 with Count passing 0 after wrap -> timer_int_o stays 0.
- Write Count=32'hFFFFFFFE -> count reads FFFFFFFF then 0 on subsequent cycles (wrap).
- excepttype_i=8, current_inst_addr_i=32'h100, is_in_delayslot_i=1, EXL=0 -> epc_o=32'hFC, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1. A second exception with addr 32'h200 -> epc_o unchanged; eret -> status_o[1]=0.
- Same-cycle write Status=0 and excepttype_i=32'hc -> status_o=32'h00000002, cause_o[6:2]=12.
- int_i=6'b100001 -> cause_o[15:10]=6'b100001 the next cycle. Write Cause=32'hFFFFFFFF with no exception -> only bits 23, 22, 9 and 8 are set; other bits hold hardware values. Assert rst mid-run -> all outputs return to reset values after one edge.
